// File: rtl/uxa_ram_arbiter.sv
// uxa_ram_arbiter: lets the MGIA video fetcher (read-only) and the CPU (read/write)
// share one 16-bit Wishbone-style RAM slave port.
//
// Video has fixed priority. A starvation counter forces a CPU win after the CPU has
// lost STARVE contended arbitrations. Ownership lasts for the whole bus cycle (CYC),
// and every change of owner goes through one idle cycle. A per-transfer watchdog
// turns a slave that never acknowledges into a one-cycle ERR pulse.
//
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-low reset
//   V_*                   video master (address, cycle, strobe in; data, ack, err out)
//   C_*                   CPU master (address, data, write enable, byte selects,
//                         cycle, strobe in; data, ack, err out)
//   M_*                   RAM slave port
//   GNT_O                 registered grant: 00 idle, 01 video, 10 CPU
module uxa_ram_arbiter #(
    parameter int unsigned AW      = 13,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned STARVE  = 64
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [AW:1]   V_ADR_I,
    input  logic          V_CYC_I,
    input  logic          V_STB_I,
    output logic [15:0]   V_DAT_O,
    output logic          V_ACK_O,
    output logic          V_ERR_O,
    input  logic [AW:1]   C_ADR_I,
    input  logic [15:0]   C_DAT_I,
    output logic [15:0]   C_DAT_O,
    input  logic          C_WE_I,
    input  logic [1:0]    C_SEL_I,
    input  logic          C_CYC_I,
    input  logic          C_STB_I,
    output logic          C_ACK_O,
    output logic          C_ERR_O,
    output logic [AW:1]   M_ADR_O,
    output logic [15:0]   M_DAT_O,
    input  logic [15:0]   M_DAT_I,
    output logic          M_WE_O,
    output logic [1:0]    M_SEL_O,
    output logic          M_CYC_O,
    output logic          M_STB_O,
    input  logic          M_ACK_I,
    output logic [1:0]    GNT_O
);

    // State encoding doubles as the grant code driven on GNT_O.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StVid  = 2'b01,
        StCpu  = 2'b10
    } state_e;

    localparam logic [7:0]  StarveLim = 8'(STARVE);
    localparam logic [15:0] WdLast    = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic [15:0] wdog_q, wdog_d;

    logic gnt_vid, gnt_cpu, cpu_force, wd_hit;

    assign gnt_vid   = (state_q == StVid);
    assign gnt_cpu   = (state_q == StCpu);
    assign cpu_force = C_CYC_I && (starve_q >= StarveLim);

    // Arbitration and starvation bookkeeping.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_force) begin
                    state_d  = StCpu;
                    starve_d = 8'd0;
                end else if (V_CYC_I) begin
                    state_d = StVid;
                    // Only a contended video win counts against the CPU.
                    if (C_CYC_I && starve_q != 8'hff) begin
                        starve_d = starve_q + 8'd1;
                    end
                end else if (C_CYC_I) begin
                    state_d  = StCpu;
                    starve_d = 8'd0;
                end
            end
            StVid: begin
                if (!V_CYC_I) state_d = StIdle;
            end
            StCpu: begin
                if (!C_CYC_I) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // RAM port steering from the registered grant.
    always_comb begin
        M_ADR_O = '0;
        M_DAT_O = 16'h0000;
        M_WE_O  = 1'b0;
        M_SEL_O = 2'b00;
        M_CYC_O = 1'b0;
        M_STB_O = 1'b0;
        if (gnt_vid) begin
            M_ADR_O = V_ADR_I;
            M_SEL_O = 2'b11;
            M_CYC_O = 1'b1;
            M_STB_O = V_STB_I;
        end else if (gnt_cpu) begin
            M_ADR_O = C_ADR_I;
            M_DAT_O = C_DAT_I;
            M_WE_O  = C_WE_I;
            M_SEL_O = C_SEL_I;
            M_CYC_O = C_CYC_I;
            M_STB_O = C_STB_I;
        end
    end

    // Terminal count is decoded combinationally so an ACK in the same cycle can veto ERR.
    assign wd_hit = M_CYC_O && M_STB_O && !M_ACK_I && (wdog_q == WdLast);

    always_comb begin
        wdog_d = 16'd0;
        if (state_q != StIdle && state_d == state_q && M_STB_O && !M_ACK_I && !wd_hit) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    assign V_ACK_O = M_ACK_I & gnt_vid & V_STB_I;
    assign C_ACK_O = M_ACK_I & gnt_cpu & C_STB_I;
    assign V_ERR_O = wd_hit & gnt_vid;
    assign C_ERR_O = wd_hit & gnt_cpu;
    assign V_DAT_O = M_DAT_I;
    assign C_DAT_O = M_DAT_I;
    assign GNT_O   = state_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= StIdle;
            starve_q <= 8'd0;
            wdog_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_uxa_ram_arbiter.sv
module tb_uxa_ram_arbiter;

    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:1]   v_adr;
    logic          v_cyc, v_stb;
    logic [15:0]   v_dat_o;
    logic          v_ack, v_err;
    logic [AW:1]   c_adr;
    logic [15:0]   c_dat_i, c_dat_o;
    logic          c_we;
    logic [1:0]    c_sel;
    logic          c_cyc, c_stb;
    logic          c_ack, c_err;
    logic [AW:1]   m_adr;
    logic [15:0]   m_dat_o, m_dat_i;
    logic          m_we;
    logic [1:0]    m_sel;
    logic          m_cyc, m_stb, m_ack;
    logic [1:0]    gnt;

    int checks = 0;
    int errors = 0;

    uxa_ram_arbiter #(
        .AW      (AW),
        .TIMEOUT (8),
        .STARVE  (4)
    ) dut (
        .CLK_I   (clk),
        .RST_I   (rst_n),
        .V_ADR_I (v_adr),
        .V_CYC_I (v_cyc),
        .V_STB_I (v_stb),
        .V_DAT_O (v_dat_o),
        .V_ACK_O (v_ack),
        .V_ERR_O (v_err),
        .C_ADR_I (c_adr),
        .C_DAT_I (c_dat_i),
        .C_DAT_O (c_dat_o),
        .C_WE_I  (c_we),
        .C_SEL_I (c_sel),
        .C_CYC_I (c_cyc),
        .C_STB_I (c_stb),
        .C_ACK_O (c_ack),
        .C_ERR_O (c_err),
        .M_ADR_O (m_adr),
        .M_DAT_O (m_dat_o),
        .M_DAT_I (m_dat_i),
        .M_WE_O  (m_we),
        .M_SEL_O (m_sel),
        .M_CYC_O (m_cyc),
        .M_STB_O (m_stb),
        .M_ACK_I (m_ack),
        .GNT_O   (gnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        v_adr = '0; v_cyc = 1'b0; v_stb = 1'b0;
        c_adr = '0; c_dat_i = 16'h0; c_we = 1'b0; c_sel = 2'b00;
        c_cyc = 1'b0; c_stb = 1'b0;
        m_dat_i = 16'h0; m_ack = 1'b0;
        #3;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_mcyc", 32'(m_cyc), 0);
        chk("rst_mstb", 32'(m_stb), 0);
        chk("rst_acks", 32'({v_ack, c_ack}), 0);
        chk("rst_errs", 32'({v_err, c_err}), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // 1. Video-only read
        v_cyc = 1'b1; v_stb = 1'b1; v_adr = 13'h0AA;
        #1;
        chk("v1_pre_gnt", 32'(gnt), 0);
        chk("v1_pre_mcyc", 32'(m_cyc), 0);
        cyc();
        chk("v1_gnt", 32'(gnt), 1);
        chk("v1_mcyc", 32'(m_cyc), 1);
        chk("v1_madr", 32'(m_adr), 'h0AA);
        chk("v1_mwe_sel", 32'({m_we, m_sel}), 3);
        chk("v1_vack_noack", 32'(v_ack), 0);
        m_ack = 1'b1; m_dat_i = 16'h1234;
        #1;
        chk("v1_vack", 32'(v_ack), 1);
        chk("v1_vdat", 32'(v_dat_o), 'h1234);
        chk("v1_cack", 32'(c_ack), 0);
        cyc();
        v_cyc = 1'b0; v_stb = 1'b0; m_ack = 1'b0;
        cyc();
        chk("v1_rel_gnt", 32'(gnt), 0);
        chk("v1_rel_mcyc", 32'(m_cyc), 0);

        // 2. CPU write with a video strobe pending on the side
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b1; c_sel = 2'b10;
        c_adr = 13'h0123; c_dat_i = 16'hBEEF;
        cyc();
        chk("c2_gnt", 32'(gnt), 2);
        chk("c2_mwe", 32'(m_we), 1);
        chk("c2_msel", 32'(m_sel), 2);
        chk("c2_madr", 32'(m_adr), 'h0123);
        chk("c2_mdat", 32'(m_dat_o), 'hBEEF);
        chk("c2_cack_noack", 32'(c_ack), 0);
        v_stb = 1'b1;
        m_ack = 1'b1;
        #1;
        chk("c2_cack", 32'(c_ack), 1);
        chk("c2_vack_nonowner", 32'(v_ack), 0);
        cyc();
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0; m_ack = 1'b0; v_stb = 1'b0;
        cyc();
        chk("c2_rel_gnt", 32'(gnt), 0);

        // 3. Simultaneous requests: video first, one idle bubble, then CPU
        v_cyc = 1'b1; v_stb = 1'b1; c_cyc = 1'b1; c_stb = 1'b1;
        cyc();
        chk("s3_gnt_vid", 32'(gnt), 1);
        cyc();
        chk("s3_gnt_hold", 32'(gnt), 1);
        v_cyc = 1'b0; v_stb = 1'b0;
        cyc();
        chk("s3_bubble_gnt", 32'(gnt), 0);
        chk("s3_bubble_mcyc", 32'(m_cyc), 0);
        cyc();
        chk("s3_gnt_cpu", 32'(gnt), 2);
        c_cyc = 1'b0; c_stb = 1'b0;
        cyc();

        // 4. Starvation with STARVE=4: four video wins, fifth contended goes to CPU
        c_cyc = 1'b1; c_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v_cyc = 1'b1; v_stb = 1'b1;
            cyc();
            chk($sformatf("st4_vid_win%0d", i), 32'(gnt), 1);
            v_cyc = 1'b0; v_stb = 1'b0;
            cyc();
            chk($sformatf("st4_idle%0d", i), 32'(gnt), 0);
        end
        v_cyc = 1'b1; v_stb = 1'b1;
        cyc();
        chk("st4_forced_cpu", 32'(gnt), 2);
        c_cyc = 1'b0; c_stb = 1'b0;
        v_cyc = 1'b0; v_stb = 1'b0;
        cyc();
        // Counter was cleared: a new contended arbitration goes to video again.
        v_cyc = 1'b1; v_stb = 1'b1; c_cyc = 1'b1; c_stb = 1'b1;
        cyc();
        chk("st4_cleared_vid", 32'(gnt), 1);
        v_cyc = 1'b0; v_stb = 1'b0; c_cyc = 1'b0; c_stb = 1'b0;
        cyc();
        cyc();

        // 5. Watchdog with TIMEOUT=8: ERR on the 8th cycle after STB, one cycle wide
        c_cyc = 1'b1; c_stb = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("to5_cerr_k%0d", k), 32'(c_err), (k == 8) ? 1 : 0);
            chk($sformatf("to5_verr_k%0d", k), 32'(v_err), 0);
            chk($sformatf("to5_gnt_k%0d", k), 32'(gnt), 2);
        end
        c_cyc = 1'b0; c_stb = 1'b0;
        cyc();
        chk("to5_rel_gnt", 32'(gnt), 0);

        // ACK landing on the terminal count suppresses ERR
        c_cyc = 1'b1; c_stb = 1'b1;
        for (int k = 1; k <= 8; k++) cyc();
        m_ack = 1'b1;
        #1;
        chk("to5_ackwin_err", 32'(c_err), 0);
        chk("to5_ackwin_ack", 32'(c_ack), 1);
        m_ack = 1'b0;
        c_cyc = 1'b0; c_stb = 1'b0;
        cyc();

        // 6. Asynchronous reset in the middle of a CPU transfer
        c_cyc = 1'b1; c_stb = 1'b1;
        cyc();
        m_ack = 1'b1;
        #1;
        chk("r6_pre_cack", 32'(c_ack), 1);
        rst_n = 1'b0;
        #1;
        chk("r6_mcyc", 32'(m_cyc), 0);
        chk("r6_mstb", 32'(m_stb), 0);
        chk("r6_cack", 32'(c_ack), 0);
        chk("r6_gnt", 32'(gnt), 0);
        c_cyc = 1'b0; c_stb = 1'b0; m_ack = 1'b0;
        cyc();
        rst_n = 1'b1;
        v_cyc = 1'b1; v_stb = 1'b1;
        cyc();
        chk("r6_after_gnt", 32'(gnt), 1);
        chk("r6_after_mcyc", 32'(m_cyc), 1);
        v_cyc = 1'b0; v_stb = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
